// File: rtl/fp16_vec_accumulator.sv
// ---------------------------------------------------------------------------
// fp16_vec_accumulator
//
// Purpose:
//   Streaming reduction front-end for an external combinational FP16 adder.
//   Beats of a vector arrive on a valid/ready stream. Each beat is added to
//   the running accumulator by the external adder (add_a + add_b -> add_sum),
//   and the sum is registered back into the accumulator. When a vector ends,
//   the total is presented on the output stream and held until it is taken.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     input beat valid
//   in_ready     block can accept a beat (high in ACC, low in HOLD)
//   in_data      FP16 operand of the current beat
//   in_last      current beat is the final beat of the vector
//   add_a        adder operand F1, always the accumulator register
//   add_b        adder operand F2, always in_data (combinational)
//   add_sum      adder result F3, combinational add_a + add_b
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_data     accumulated FP16 sum (zero while no result is held)
//   out_count    number of beats summed into out_data
//   out_special  result exponent is all ones (Inf or NaN)
//   out_trunc    vector was cut at MAX_LEN without in_last
// ---------------------------------------------------------------------------
module fp16_vec_accumulator #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_special,
  output logic             out_trunc
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Count value of the beat that fills the vector to MAX_LEN.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [15:0]      acc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] out_count_q;
  logic             trunc_q;

  logic             accept;
  logic             end_of_vec;
  logic             handoff;

  // The adder sits in a purely combinational loop around the accumulator:
  // its operands never depend on in_valid, so the sum is always ready to
  // be captured on whichever edge accepts a beat.
  assign add_a = acc;
  assign add_b = in_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode. A vector ends either on in_last or
  // when the beat being accepted is the MAX_LEN-th one, so the counter can
  // never wrap. In HOLD nothing is accepted, including the handoff cycle.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    end_of_vec = 1'b0;
    handoff    = 1'b0;
    case (state)
      ACC: begin
        in_ready   = 1'b1;
        accept     = in_valid;
        end_of_vec = in_valid && (in_last || (count == LAST_IDX));
        if (end_of_vec) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        handoff   = out_ready;
        if (handoff) begin
          state_next = ACC;
        end
      end
      default: begin
        state_next = ACC;
      end
    endcase
  end

  // Accumulator, beat counter and result metadata. The accumulator restarts
  // from +0 after each handoff, so the first beat of a vector is summed with
  // +0 by the adder. Special values are not interpreted; whatever the adder
  // returns is stored, which lets NaN/Inf propagate to the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= 16'h0000;
      count       <= '0;
      out_count_q <= '0;
      trunc_q     <= 1'b0;
    end else if (handoff) begin
      acc         <= 16'h0000;
      count       <= '0;
      out_count_q <= '0;
      trunc_q     <= 1'b0;
    end else if (accept) begin
      acc   <= add_sum;
      count <= count + CNT_ONE;
      if (end_of_vec) begin
        out_count_q <= count + CNT_ONE;
        trunc_q     <= ~in_last;
      end
    end
  end

  // The result is only exposed while it is being offered; the partial sum
  // of a vector in progress stays internal.
  assign out_data    = out_valid ? acc : 16'h0000;
  assign out_special = out_valid && (acc[14:10] == 5'h1F);
  assign out_count   = out_count_q;
  assign out_trunc   = trunc_q;

endmodule

// File: tb/tb_fp16_vec_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fp16_vec_accumulator
//
// Drives fp16_vec_accumulator (MAX_LEN=4) through directed vectors and a
// randomized stream. The external FP16 adder is modelled here with real
// arithmetic and round-to-nearest-even, and a vector-level model folds that
// adder over the beats of each vector to predict every result.
// ---------------------------------------------------------------------------
module tb_fp16_vec_accumulator;

  localparam int MAXL = 4;
  localparam int CW   = $clog2(MAXL + 1);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          in_last;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic [15:0]   add_sum;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [CW-1:0] out_count;
  logic          out_special;
  logic          out_trunc;

  int checks;
  int errors;

  // Vector-level reference state.
  logic [15:0] exp_acc;
  int          exp_cnt;
  logic [15:0] exp_data;
  int          exp_count_o;
  logic        exp_trunc;
  logic        ended;

  fp16_vec_accumulator #(.MAX_LEN(MAXL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_special(out_special),
    .out_trunc  (out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FP16 arithmetic model ----------------
  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) begin
      for (int i = 0; i < n; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -n; i++) r = r / 2.0;
    end
    return r;
  endfunction

  function automatic int rne(input real x);
    real fl;
    real d;
    int  i;
    fl = $floor(x);
    d  = x - fl;
    i  = $rtoi(fl);
    if (d > 0.5) i = i + 1;
    else if (d == 0.5 && (i % 2) == 1) i = i + 1;
    return i;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    real m;
    if (h[14:10] == 5'd0) m = real'(int'(h[9:0])) * pow2(-24);
    else m = (1024.0 + real'(int'(h[9:0]))) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real v);
    logic s;
    real  a;
    int   e;
    int   m;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a < pow2(-14)) begin
      m = rne(a * pow2(24));
      return {s, 15'(m)};
    end
    e = -14;
    for (int k = 0; k < 40 && a >= pow2(e + 1); k++) e = e + 1;
    m = rne(a / pow2(e - 10));
    if (m == 2048) begin
      e = e + 1;
      m = 1024;
    end
    if (e > 15) return {s, 15'h7C00};
    return {s, 5'(e + 15), 10'(m - 1024)};
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    real  s;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    if (a_nan || b_nan) return 16'h7E00;
    if (a_inf && b_inf && (a[15] != b[15])) return 16'h7E00;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a == 16'h8000 && b == 16'h8000) return 16'h8000;
    s = fp16_to_real(a) + fp16_to_real(b);
    if (s == 0.0) return 16'h0000;
    return real_to_fp16(s);
  endfunction

  // The external adder sits combinationally on the DUT's operand outputs.
  always_comb add_sum = fp16_add(add_a, add_b);

  function automatic logic [15:0] rand_fp16();
    case ($urandom_range(0, 15))
      0:       return $urandom_range(0, 1) == 0 ? 16'h7C00 : 16'hFC00;
      1:       return 16'h7E01;
      2:       return $urandom_range(0, 1) == 0 ? 16'h0000 : 16'h8000;
      3:       return {1'($urandom_range(0, 1)), 5'd30, 10'($urandom)};
      4:       return {1'($urandom_range(0, 1)), 5'd0, 10'($urandom)};
      default: return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
    endcase
  endfunction

  // ---------------- checking and stimulus tasks ----------------
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one beat, step one clock, and check the block's reaction.
  task automatic applyStimulus(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    checkOutput("in_ready_acc", 16'(in_ready), 16'd1);
    checkOutput("add_a_acc", add_a, exp_acc);
    checkOutput("add_b_track", add_b, d);
    exp_acc = fp16_add(exp_acc, d);
    exp_cnt = exp_cnt + 1;
    ended   = last || (exp_cnt == MAXL);
    if (ended) begin
      exp_data    = exp_acc;
      exp_count_o = exp_cnt;
      exp_trunc   = !last;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ended) begin
      checkOutput("out_valid_eov", 16'(out_valid), 16'd1);
      checkOutput("in_ready_hold", 16'(in_ready), 16'd0);
      checkOutput("out_data", out_data, exp_data);
      checkOutput("out_count", 16'(out_count), 16'(exp_count_o));
      checkOutput("out_trunc", 16'(out_trunc), 16'(exp_trunc));
      checkOutput("out_special", 16'(out_special), 16'(exp_data[14:10] == 5'h1F));
    end else begin
      checkOutput("out_valid_mid", 16'(out_valid), 16'd0);
      checkOutput("in_ready_mid", 16'(in_ready), 16'd1);
    end
  endtask

  // A cycle with no beat offered must leave the accumulation untouched.
  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    checkOutput("idle_add_a", add_a, exp_acc);
    checkOutput("idle_add_b", add_b, in_data);
    checkOutput("idle_out_valid", 16'(out_valid), 16'd0);
    in_last = 1'b0;
  endtask

  // Hold the result for some cycles (optionally with beats pushing), then take it.
  task automatic release_result(input int waits, input logic junk);
    for (int i = 0; i < waits; i++) begin
      in_valid = junk;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checkOutput("hold_out_valid", 16'(out_valid), 16'd1);
      checkOutput("hold_out_data", out_data, exp_data);
      checkOutput("hold_out_count", 16'(out_count), 16'(exp_count_o));
      checkOutput("hold_in_ready", 16'(in_ready), 16'd0);
    end
    in_valid  = junk;
    out_ready = 1'b1;
    #1;
    checkOutput("handoff_in_ready", 16'(in_ready), 16'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    checkOutput("post_out_valid", 16'(out_valid), 16'd0);
    checkOutput("post_in_ready", 16'(in_ready), 16'd1);
    checkOutput("post_out_count", 16'(out_count), 16'd0);
    checkOutput("post_out_trunc", 16'(out_trunc), 16'd0);
    checkOutput("post_add_a", add_a, 16'h0000);
    exp_acc = 16'h0000;
    exp_cnt = 0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
    checkOutput("rst_out_data", out_data, 16'h0000);
    checkOutput("rst_out_count", 16'(out_count), 16'd0);
    checkOutput("rst_out_trunc", 16'(out_trunc), 16'd0);
    checkOutput("rst_add_a", add_a, 16'h0000);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_rel_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_rel_in_ready", 16'(in_ready), 16'd1);
    exp_acc = 16'h0000;
    exp_cnt = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    exp_acc   = 16'h0000;
    exp_cnt   = 0;
    exp_data  = 16'h0000;
    exp_count_o = 0;
    exp_trunc = 1'b0;
    ended     = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;

    $display("[TB] reset state");
    #3;
    checkOutput("init_out_valid", 16'(out_valid), 16'd0);
    checkOutput("init_out_data", out_data, 16'h0000);
    checkOutput("init_out_count", 16'(out_count), 16'd0);
    checkOutput("init_out_special", 16'(out_special), 16'd0);
    checkOutput("init_out_trunc", 16'(out_trunc), 16'd0);
    checkOutput("init_add_a", add_a, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("init_in_ready", 16'(in_ready), 16'd1);

    $display("[TB] 1+2+3");
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h4000, 1'b0);
    applyStimulus(16'h4200, 1'b1);
    checkOutput("sum6_data", out_data, 16'h4600);
    checkOutput("sum6_count", 16'(out_count), 16'd3);
    release_result(0, 1'b0);

    $display("[TB] 5-4 then back-to-back 1.5");
    applyStimulus(16'h4500, 1'b0);
    applyStimulus(16'hC400, 1'b1);
    checkOutput("diff_data", out_data, 16'h3C00);
    checkOutput("diff_count", 16'(out_count), 16'd2);
    release_result(0, 1'b0);
    applyStimulus(16'h3E00, 1'b1);
    checkOutput("restart_data", out_data, 16'h3E00);
    release_result(0, 1'b0);

    $display("[TB] +Inf + -Inf");
    applyStimulus(16'h7C00, 1'b0);
    applyStimulus(16'hFC00, 1'b1);
    checkOutput("nan_special", 16'(out_special), 16'd1);
    checkOutput("nan_exp", 16'(out_data[14:10]), 16'h1F);
    checkOutput("nan_frac_nz", 16'(out_data[9:0] != 10'd0), 16'd1);
    release_result(1, 1'b0);
    applyStimulus(16'h4000, 1'b1);
    checkOutput("after_nan_data", out_data, 16'h4000);
    checkOutput("after_nan_special", 16'(out_special), 16'd0);
    release_result(0, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(16'h4000, 1'b0);
    applyStimulus(16'h4000, 1'b1);
    checkOutput("bp_data", out_data, 16'h4400);
    release_result(3, 1'b1);

    $display("[TB] truncation at MAX_LEN");
    for (int i = 0; i < 4; i++) applyStimulus(16'h3C00, 1'b0);
    checkOutput("trunc_data", out_data, 16'h4400);
    checkOutput("trunc_count", 16'(out_count), 16'd4);
    checkOutput("trunc_flag", 16'(out_trunc), 16'd1);
    release_result(0, 1'b0);
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h3C00, 1'b1);
    checkOutput("trunc_next_data", out_data, 16'h4000);
    checkOutput("trunc_next_count", 16'(out_count), 16'd2);
    release_result(0, 1'b0);

    $display("[TB] last on the MAX_LEN-th beat");
    for (int i = 0; i < 3; i++) applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h3C00, 1'b1);
    checkOutput("full_last_trunc", 16'(out_trunc), 16'd0);
    release_result(0, 1'b0);

    $display("[TB] reset mid-vector");
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h3C00, 1'b0);
    reset_pulse();
    applyStimulus(16'h3C00, 1'b1);
    checkOutput("post_rst_data", out_data, 16'h3C00);
    checkOutput("post_rst_count", 16'(out_count), 16'd1);
    release_result(0, 1'b0);

    $display("[TB] randomized stream");
    for (int v = 0; v < 60; v++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int b = 1; b <= len; b++) begin
        if ($urandom_range(0, 3) == 0) idle_cycle();
        applyStimulus(rand_fp16(), b == len);
        if (ended) begin
          if ($urandom_range(0, 9) == 0) reset_pulse();
          else release_result(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
